// File: rtl/bp_pkg.sv
// Branch predictor configuration types and saturating counter helpers.
package bp_pkg;
    typedef enum logic {
        BP_GSELECT = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Widest counter the helpers support; callers cast down to their own width.
    localparam int CTR_MAX_W = 8;

    function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [CTR_MAX_W-1:0] max_v;
        max_v = {CTR_MAX_W{1'b1}} >> (CTR_MAX_W - w);
        if (v >= max_v) begin
            return max_v;
        end else begin
            return v + {{(CTR_MAX_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] v);
        if (v == {CTR_MAX_W{1'b0}}) begin
            return {CTR_MAX_W{1'b0}};
        end else begin
            return v - {{(CTR_MAX_W-1){1'b0}}, 1'b1};
        end
    endfunction
endpackage

// File: rtl/mips_core_pkg.sv
// Core-wide types shared by the fetch and resolution stages.
package mips_core_pkg;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

// File: rtl/bp_ghr.sv
// Speculative global history: shifts in each prediction, repaired from the
// branch snapshot on a misprediction (repair has priority over the shift).
module bp_ghr #(
    parameter int HIST_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_shift,
    input  logic                 i_shift_bit,
    input  logic                 i_repair,
    input  logic [HIST_BITS-1:0] i_repair_ghr,
    input  logic                 i_repair_bit,
    output logic [HIST_BITS-1:0] o_ghr
);
    logic [HIST_BITS-1:0] r_ghr;
    logic [HIST_BITS-1:0] w_ghr_next;
    logic                 w_unused;

    assign w_unused = i_repair_ghr[HIST_BITS-1];

    // Next-history selection; a repair discards a same-cycle wrong-path shift.
    always_comb begin
        w_ghr_next = r_ghr;
        if (i_repair) begin
            w_ghr_next = {i_repair_ghr[HIST_BITS-2:0], i_repair_bit};
        end else if (i_shift) begin
            w_ghr_next = {r_ghr[HIST_BITS-2:0], i_shift_bit};
        end else begin
            w_ghr_next = r_ghr;
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= {HIST_BITS{1'b0}};
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

    assign o_ghr = r_ghr;
endmodule

// File: rtl/gselect_gshare_predictor.sv
// Global-history branch predictor with gselect or gshare indexing, a
// sequential counter-table init sweep and speculative history repair.
module gselect_gshare_predictor
    import mips_core_pkg::*;
    import bp_pkg::*;
#(
    parameter int       HIST_BITS = 4,
    parameter int       PC_BITS   = 4,
    parameter int       PC_LSB    = 4,
    parameter bp_mode_e MODE      = BP_GSELECT,
    parameter int       CTR_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    input  logic [ADDR_WIDTH-1:0] i_req_target,
    output BranchOutcome          o_req_prediction,
    output logic [HIST_BITS-1:0]  o_req_ghr,
    output logic                  o_ready,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  logic [HIST_BITS-1:0]  i_fb_ghr,
    input  BranchOutcome          i_fb_prediction,
    input  BranchOutcome          i_fb_outcome
);
    localparam int IDX   = (MODE == BP_GSHARE) ? PC_BITS : HIST_BITS + PC_BITS;
    localparam int DEPTH = 1 << IDX;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = {1'b1, {(CTR_BITS-1){1'b0}}};

    if (MODE == BP_GSHARE && HIST_BITS != PC_BITS) begin : g_bad_gshare
        $error("gshare indexing needs HIST_BITS == PC_BITS");
    end
    if (CTR_BITS < 2 || CTR_BITS > CTR_MAX_W || HIST_BITS < 2) begin : g_bad_width
        $error("unsupported CTR_BITS or HIST_BITS");
    end

    bp_state_e             r_state, w_state_next;
    logic [IDX-1:0]        r_k, w_k_next;
    logic [CTR_BITS-1:0]   r_table [DEPTH];
    logic [HIST_BITS-1:0]  w_ghr;
    logic [PC_BITS-1:0]    w_req_field, w_fb_field;
    logic [IDX-1:0]        w_req_idx, w_fb_idx;
    logic                  w_run;
    logic [CTR_BITS-1:0]   w_fb_inc, w_fb_dec;
    logic                  w_tbl_we;
    logic [IDX-1:0]        w_tbl_widx;
    logic [CTR_BITS-1:0]   w_tbl_wdata;
    logic                  w_unused;

    assign w_unused    = ^{i_req_target, i_req_pc, i_fb_pc};
    assign w_req_field = i_req_pc[PC_LSB +: PC_BITS];
    assign w_fb_field  = i_fb_pc[PC_LSB +: PC_BITS];

    if (MODE == BP_GSHARE) begin : g_gshare
        assign w_req_idx = w_ghr ^ w_req_field;
        assign w_fb_idx  = i_fb_ghr ^ w_fb_field;
    end else begin : g_gselect
        assign w_req_idx = {w_ghr, w_req_field};
        assign w_fb_idx  = {i_fb_ghr, w_fb_field};
    end

    assign w_run = (r_state == BP_RUN);

    // Init sweep sequencing; k wraps back to zero exactly at the INIT exit.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        case (r_state)
            BP_INIT: begin
                w_k_next = r_k + {{(IDX-1){1'b0}}, 1'b1};
                if (r_k == {IDX{1'b1}}) begin
                    w_state_next = BP_RUN;
                end else begin
                    w_state_next = BP_INIT;
                end
            end
            BP_RUN: begin
                w_state_next = BP_RUN;
                w_k_next     = {IDX{1'b0}};
            end
            default: begin
                w_state_next = BP_INIT;
                w_k_next     = {IDX{1'b0}};
            end
        endcase
    end

    // FSM state and sweep index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BP_INIT;
            r_k     <= {IDX{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    assign w_fb_inc = CTR_BITS'(sat_inc(CTR_MAX_W'(r_table[w_fb_idx]), CTR_BITS));
    assign w_fb_dec = CTR_BITS'(sat_dec(CTR_MAX_W'(r_table[w_fb_idx])));

    // Single table write port: sweep writes in INIT, feedback training in RUN.
    always_comb begin
        w_tbl_we    = 1'b0;
        w_tbl_widx  = r_k;
        w_tbl_wdata = CTR_WEAK_TAKEN;
        if (rst) begin
            w_tbl_we = 1'b0;
        end else if (!w_run) begin
            w_tbl_we = 1'b1;
        end else if (i_fb_valid) begin
            w_tbl_we    = 1'b1;
            w_tbl_widx  = w_fb_idx;
            w_tbl_wdata = (i_fb_outcome == TAKEN) ? w_fb_inc : w_fb_dec;
        end else begin
            w_tbl_we = 1'b0;
        end
    end

    // Counter table storage; contents are only meaningful after the sweep.
    always_ff @(posedge clk) begin
        if (w_tbl_we) begin
            r_table[w_tbl_widx] <= w_tbl_wdata;
        end
    end

    // Prediction reads the pre-update counter, so same-index feedback is not bypassed.
    always_comb begin
        o_req_prediction = NOT_TAKEN;
        if (w_run && r_table[w_req_idx][CTR_BITS-1]) begin
            o_req_prediction = TAKEN;
        end else begin
            o_req_prediction = NOT_TAKEN;
        end
    end

    assign o_ready   = w_run;
    assign o_req_ghr = w_ghr;

    bp_ghr #(
        .HIST_BITS (HIST_BITS)
    ) u_ghr (
        .clk          (clk),
        .rst          (rst),
        .i_shift      (w_run && i_req_valid),
        .i_shift_bit  (o_req_prediction == TAKEN),
        .i_repair     (w_run && i_fb_valid && (i_fb_prediction != i_fb_outcome)),
        .i_repair_ghr (i_fb_ghr),
        .i_repair_bit (i_fb_outcome == TAKEN),
        .o_ghr        (w_ghr)
    );
endmodule

// File: tb/tb_gselect_gshare_predictor.sv
// Randomised and directed bench for the gselect/gshare predictor against an
// array-based reference model.
module tb_gselect_gshare_predictor;
    import mips_core_pkg::*;
    import bp_pkg::*;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_pc = 32'd0;
    logic [31:0]  req_target = 32'd0;
    BranchOutcome pred;
    logic [3:0]   ghr;
    logic         ready;
    logic         fb_valid = 1'b0;
    logic [31:0]  fb_pc = 32'd0;
    logic [3:0]   fb_ghr = 4'd0;
    BranchOutcome fb_pred = NOT_TAKEN;
    BranchOutcome fb_out = NOT_TAKEN;

    logic         g_rst = 1'b1;
    logic         g_req_valid = 1'b0;
    logic [31:0]  g_req_pc = 32'd0;
    BranchOutcome g_pred;
    logic [3:0]   g_ghr;
    logic         g_ready;
    logic         g_fb_valid = 1'b0;
    logic [31:0]  g_fb_pc = 32'd0;
    logic [3:0]   g_fb_ghr = 4'd0;
    BranchOutcome g_fb_pred = NOT_TAKEN;
    BranchOutcome g_fb_out = NOT_TAKEN;

    gselect_gshare_predictor dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_pc(req_pc), .i_req_target(req_target),
        .o_req_prediction(pred), .o_req_ghr(ghr), .o_ready(ready),
        .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_ghr(fb_ghr),
        .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out)
    );

    gselect_gshare_predictor #(.MODE(BP_GSHARE)) dut_gshare (
        .clk(clk), .rst(g_rst),
        .i_req_valid(g_req_valid), .i_req_pc(g_req_pc), .i_req_target(req_target),
        .o_req_prediction(g_pred), .o_req_ghr(g_ghr), .o_ready(g_ready),
        .i_fb_valid(g_fb_valid), .i_fb_pc(g_fb_pc), .i_fb_ghr(g_fb_ghr),
        .i_fb_prediction(g_fb_pred), .i_fb_outcome(g_fb_out)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_ctr [256];
    int m_ghr;
    int g_ctr [16];
    int g_hist;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input int h, input logic [31:0] pc);
        return ((h & 15) * 16) + ((pc / 16) % 16);
    endfunction

    function automatic int sat(input int v, input bit up);
        if (up) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    // Applies one cycle of stimulus starting at a falling edge, checks the
    // combinational prediction, then advances the model.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit fv,
                        input logic [31:0] fpc, input int fg, input bit fp, input bit fo);
        bit exp_pred;
        int fi;
        req_valid = rv; req_pc = rpc;
        fb_valid = fv; fb_pc = fpc; fb_ghr = 4'(fg);
        fb_pred = fp ? TAKEN : NOT_TAKEN;
        fb_out  = fo ? TAKEN : NOT_TAKEN;
        #1;
        exp_pred = (m_ctr[m_idx(m_ghr, rpc)] >= 2);
        check_eq("pred", pred, exp_pred);
        check_eq("ghr", ghr, m_ghr);
        if (fv) begin
            fi = m_idx(fg, fpc);
            m_ctr[fi] = sat(m_ctr[fi], fo);
        end
        if (fv && (fp != fo)) m_ghr = ((fg * 2) + fo) % 16;
        else if (rv) m_ghr = ((m_ghr * 2) + exp_pred) % 16;
        @(negedge clk);
        req_valid = 1'b0; fb_valid = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input bit exp);
        req_valid = 1'b0; fb_valid = 1'b0; req_pc = pc;
        #1;
        check_eq(tag, pred, exp);
    endtask

    // One-cycle reset followed by the full sweep; traffic during INIT must be ignored.
    task automatic reset_sweep();
        rst = 1'b1;
        req_valid = 1'b1; req_pc = 32'h10;
        fb_valid = 1'b1; fb_pc = 32'h10; fb_ghr = 4'd0;
        fb_pred = NOT_TAKEN; fb_out = TAKEN;
        @(negedge clk); #1;
        check_eq("rst_ready", ready, 0);
        check_eq("rst_ghr", ghr, 0);
        check_eq("rst_pred", pred, 0);
        rst = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            @(posedge clk); #1;
            check_eq("init_ready", ready, (c == 256));
            check_eq("init_ghr", ghr, 0);
            if (c < 256) check_eq("init_pred", pred, 0);
        end
        req_valid = 1'b0; fb_valid = 1'b0;
        for (int i = 0; i < 256; i++) m_ctr[i] = 2;
        m_ghr = 0;
        @(negedge clk);
    endtask

    initial begin
        reset_sweep();
        for (int i = 0; i < 4; i++) probe("fresh_taken", $urandom, 1'b1);

        // Three taken predictions walk the history 0 -> 1 -> 3 -> 7.
        for (int i = 0; i < 3; i++) step(1, 32'h10, 0, 0, 0, 0, 0);
        #1 check_eq("shift_ghr", ghr, 7);
        step(0, 0, 1, 32'h10, 1, 1, 0);
        #1 check_eq("repair_ghr", ghr, 2);

        // Saturation at the pc=0x10, ghr=0 entry.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h10, 0, 1, 0);
        #1 check_eq("sat_ghr", ghr, 0);
        probe("sat_zero", 32'h10, 1'b0);
        step(0, 0, 1, 32'h10, 0, 1, 1);
        probe("sat_one", 32'h10, 1'b0);
        step(0, 0, 1, 32'h10, 0, 1, 1);
        probe("sat_two", 32'h10, 1'b1);

        // Request and mispredict in the same cycle: the repair wins.
        step(1, 32'h20, 1, 32'h30, 5, 0, 1);
        #1 check_eq("simul_ghr", ghr, 11);
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 $urandom & 32'h0000_00F0, $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end

        reset_sweep();
        for (int i = 0; i < 4; i++) probe("rerun_taken", $urandom, 1'b1);

        // Gshare instance: one entry trained, every other entry left weakly taken.
        @(negedge clk);
        g_rst = 1'b0;
        repeat (15) @(posedge clk);
        #1 check_eq("g_ready_lo", g_ready, 0);
        @(posedge clk);
        #1 check_eq("g_ready_hi", g_ready, 1);
        for (int i = 0; i < 16; i++) g_ctr[i] = 2;
        g_hist = 0;
        @(negedge clk);
        g_fb_valid = 1'b1; g_fb_pc = 32'h60; g_fb_ghr = 4'b1010;
        g_fb_pred = NOT_TAKEN; g_fb_out = NOT_TAKEN;
        repeat (2) @(negedge clk);
        g_fb_valid = 1'b0;
        g_ctr[(10 ^ 6)] = 0;
        for (int e = 0; e < 16; e++) begin
            bit exp;
            g_req_valid = 1'b1;
            g_req_pc = 32'((e ^ g_hist) * 16);
            #1;
            exp = (g_ctr[e] >= 2);
            check_eq("g_entry", g_pred, exp);
            check_eq("g_ghr", g_ghr, g_hist);
            g_hist = ((g_hist * 2) + exp) % 16;
            @(negedge clk);
        end
        g_req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gselect_gshare_predictor.md
# gselect_gshare_predictor

Parametrised successor to the fixed 8-bit gselect predictor: a table of saturating counters indexed by global history combined with PC bits, either concatenated (gselect) or XORed (gshare). History is updated speculatively at prediction time and repaired from a per-branch snapshot on misprediction. A sequential init sweep replaces the single-cycle table reset. The block sits in the fetch stage, with feedback driven from the branch-resolution stage.

## Interface
- `HIST_BITS`, default 4: global history length.
- `PC_BITS`, default 4: PC bits used for indexing.
- `PC_LSB`, default 4: lowest PC bit used; the field is `pc[PC_LSB +: PC_BITS]`.
- `MODE`, default `BP_GSELECT`: `BP_GSELECT` or `BP_GSHARE`. `BP_GSHARE` requires `HIST_BITS == PC_BITS`; violation is an elaboration error.
- `CTR_BITS`, default 2: counter width, at least 2.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `i_req_valid`, in, 1: prediction request.
- `i_req_pc`, in, `ADDR_WIDTH`: PC of the requesting branch.
- `i_req_target`, in, `ADDR_WIDTH`: unused; kept for port compatibility.
- `o_req_prediction`, out, `BranchOutcome`: prediction for this cycle's request.
- `o_req_ghr`, out, `HIST_BITS`: history used for this prediction. It travels with the branch down the pipe.
- `o_ready`, out, 1: table initialised; requests are honoured only while high.
- `i_fb_valid`, in, 1: resolved-branch feedback.
- `i_fb_pc`, in, `ADDR_WIDTH`: PC of the resolved branch.
- `i_fb_ghr`, in, `HIST_BITS`: the `o_req_ghr` captured at prediction time.
- `i_fb_prediction`, in, `BranchOutcome`: the prediction that was made.
- `i_fb_outcome`, in, `BranchOutcome`: the actual outcome.

## Operation
- Index width `IDX` is `HIST_BITS + PC_BITS` in gselect mode and `PC_BITS` in gshare mode. The table holds `2^IDX` counters.
- Gselect index: `{ghr, pcfield}`. Gshare index: `ghr ^ pcfield`.
- FSM states:
  - INIT: index register `k` writes counter[k] = `2^(CTR_BITS-1)` (weakly taken) and increments each cycle. When `k` reaches `2^IDX - 1`, the next state is RUN. Outputs: `o_ready = 0`, `o_req_prediction = NOT_TAKEN`. Requests and feedback are ignored.
  - RUN: `o_ready = 1`; normal operation.
- Prediction is combinational: counter[index(spec_ghr, i_req_pc)] MSB gives TAKEN, otherwise NOT_TAKEN. `o_req_ghr = spec_ghr`.
- Speculative history: on `i_req_valid` in RUN, the next `spec_ghr` is `{spec_ghr[HIST_BITS-2:0], prediction == TAKEN}`. The newest outcome is held in bit 0.
- Feedback in RUN computes `fb_idx = index(i_fb_ghr, i_fb_pc)`.
  - The counter at `fb_idx` increments on TAKEN and decrements on NOT_TAKEN, saturating at `2^CTR_BITS - 1` and at 0.
  - Misprediction (`i_fb_prediction != i_fb_outcome`) sets `spec_ghr` to `{i_fb_ghr[HIST_BITS-2:0], i_fb_outcome == TAKEN}`.
- Simultaneous request and mispredicting feedback: the repair wins and the request's speculative shift is discarded, because that request is wrong-path. The request still receives a prediction computed from the pre-repair history.
- Simultaneous request and correct feedback: both take effect.
- Request and feedback to the same index in one cycle: the request reads the old counter value; there is no bypass.

## Timing
- Reset values: `spec_ghr = 0`, FSM in INIT, `k = 0`, `o_ready = 0`, `o_req_prediction = NOT_TAKEN`, `o_req_ghr = 0`.
- Counter contents are undefined until the INIT sweep writes them.
- `o_ready` rises exactly `2^IDX` cycles after the first cycle with `rst` low.
- Prediction latency is 0 cycles, combinational from `i_req_pc`.
- Counter and history updates become visible on the cycle after the clock edge.
- `rst` asserted mid-operation: the next cycle is INIT with `k = 0` and `spec_ghr = 0`. The full sweep repeats.
- `k` wraps only at the INIT exit and never overflows into RUN.

## Structure
- `bp_pkg` holds:
  - `bp_mode_e` (`BP_GSELECT`, `BP_GSHARE`).
  - `bp_state_e` (`BP_INIT`, `BP_RUN`).
  - The `sat_inc`/`sat_dec` functions, parametrised by width.
- `BranchOutcome` comes from `mips_core_pkg`.
- One sub-module, `bp_ghr`: the speculative history register, with shift-on-predict and repair-on-mispredict priority logic.

## Test plan
- Init sweep: default parameters, deassert `rst`. `o_ready` stays 0 for exactly 256 cycles and is 1 on cycle 257. Any PC then predicts TAKEN.
- Saturation: 4 NOT_TAKEN feedbacks with pc=0x10, ghr=0. The counter reaches 0, not wrap, and predicts NOT_TAKEN. Then 1 TAKEN, counter=1, still NOT_TAKEN. Then 1 more TAKEN, counter=2, TAKEN.
- Speculative shift and repair:
  - Three TAKEN predictions move `o_req_ghr` 0 → 1 → 3 → 7.
  - Mispredict feedback with `i_fb_ghr=1` and outcome NOT_TAKEN gives `o_req_ghr = 2` on the next cycle.
- Simultaneous events: request and mispredict feedback in the same cycle. The repaired value wins and the request's shift is lost.
- Gshare mode: HIST=PC=4, ghr=0b1010, pc field 0b0110. The entry at index 0b1100 updates and no other entry changes.
- Reset mid-run: assert `rst` for 1 cycle in RUN. `o_ready` drops next cycle, `o_req_ghr = 0`, and a fresh 256-cycle sweep runs.
